// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the colour sequence shown by the game and replays it on the player buttons.
// Latency: start_btn one cycle after the enable edge; playback begins one cycle after the registered colour strobe reads low.
// Backpressure: none; the game sets the pace, and enable low aborts to IDLE on the next cycle.
module simon_autoplayer #(
    parameter int STEP_CYCLES  = 50000001,
    parameter int PRESS_CYCLES = 2,
    parameter int GAP_CYCLES   = 30000000,
    parameter int WAIT_LIMIT   = 200000000,
    parameter int MAX_LEN      = 251
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] color,
    input  logic       color_en,
    input  logic [7:0] round,
    output logic       start_btn,
    output logic       red_btn,
    output logic       green_btn,
    output logic       blue_btn,
    output logic       yellow_btn,
    output logic       busy,
    output logic       seq_err,
    output logic       game_over,
    output logic [7:0] rec_len
);

    // One shared phase counter serves RECORD, PLAY_PRESS and PLAY_GAP, so it is sized for the largest of them.
    localparam int CMAX = (STEP_CYCLES > PRESS_CYCLES) ?
                          ((STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES) :
                          ((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES);
    localparam int CW = $clog2(CMAX + 1);
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    localparam logic [CW-1:0] HALF_STEP = CW'(STEP_CYCLES / 2);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);
    localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_SEQ, RECORD, WAIT_END, PLAY_PRESS, PLAY_GAP
    } state_t;

    state_t        state, state_n;
    logic          en_q, cen_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [7:0]    idx, idx_n;
    logic [7:0]    target_len, target_n;
    logic [7:0]    rec_len_n;
    logic          err_n, go_n, mem_we;
    logic [3:0]    btns;
    logic [1:0]    mem [MAX_LEN];

    logic cen_rise, cen_fall, en_rise;
    assign cen_rise = color_en & ~cen_q;
    assign cen_fall = ~color_en & cen_q;
    assign en_rise  = enable & ~en_q;

    // Next-state and datapath updates; enable low outranks everything outside IDLE.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        wait_n   = wait_cnt;
        idx_n    = idx;
        target_n = target_len;
        rec_len_n = rec_len;
        err_n    = seq_err;
        go_n     = 1'b0;
        mem_we   = 1'b0;
        if (state != IDLE && !enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            wait_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_rise) begin
                        state_n   = START;
                        err_n     = 1'b0;
                        rec_len_n = '0;
                    end
                end
                START: begin
                    state_n = WAIT_SEQ;
                    wait_n  = '0;
                end
                WAIT_SEQ: begin
                    if (cen_rise) begin
                        if (round == 8'd0 || {1'b0, round} > MAX_LEN9) begin
                            err_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            target_n = round;
                            idx_n    = '0;
                            cnt_n    = '0;
                            state_n  = RECORD;
                        end
                    end else if (rec_len != 8'd0 && wait_cnt == WAIT_LAST) begin
                        go_n    = 1'b1;
                        state_n = IDLE;
                    end else if (wait_cnt != WAIT_LAST) begin
                        // Saturates so a first round that never arrives cannot wrap the counter.
                        wait_n = wait_cnt + WW'(1);
                    end
                end
                RECORD: begin
                    if (cen_fall) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = (cnt == STEP_LAST) ? '0 : cnt + CW'(1);
                        if (cnt == HALF_STEP) begin
                            mem_we = 1'b1;
                            // The old sequence must reappear as the prefix of the new one.
                            if (idx < rec_len && mem[idx] != color) begin
                                err_n = 1'b1;
                            end
                            idx_n = idx + 8'd1;
                            if (idx + 8'd1 == target_len) begin
                                state_n = WAIT_END;
                            end
                        end
                    end
                end
                WAIT_END: begin
                    if (!cen_q) begin
                        rec_len_n = target_len;
                        idx_n     = '0;
                        cnt_n     = '0;
                        state_n   = PLAY_PRESS;
                    end
                end
                PLAY_PRESS: begin
                    if (cnt == PRESS_LAST) begin
                        cnt_n   = '0;
                        state_n = PLAY_GAP;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PLAY_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n = '0;
                        idx_n = idx + 8'd1;
                        if (idx + 8'd1 == rec_len) begin
                            state_n = WAIT_SEQ;
                            wait_n  = '0;
                        end else begin
                            state_n = PLAY_PRESS;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and datapath registers; en_q resets high so an enable already high at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            en_q       <= 1'b1;
            cen_q      <= 1'b0;
            cnt        <= '0;
            wait_cnt   <= '0;
            idx        <= '0;
            target_len <= '0;
            rec_len    <= '0;
            seq_err    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            en_q       <= enable;
            cen_q      <= color_en;
            cnt        <= cnt_n;
            wait_cnt   <= wait_n;
            idx        <= idx_n;
            target_len <= target_n;
            rec_len    <= rec_len_n;
            seq_err    <= err_n;
            game_over  <= go_n;
        end
    end

    // Sequence memory: no reset, every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= color;
        end
    end

    // Buttons decode straight from state, so they are one-hot during a press and zero otherwise.
    always_comb begin
        btns = 4'b0000;
        if (state == PLAY_PRESS) begin
            btns[mem[idx]] = 1'b1;
        end
    end

    assign red_btn    = btns[0];
    assign green_btn  = btns[1];
    assign blue_btn   = btns[2];
    assign yellow_btn = btns[3];
    assign start_btn  = (state == START);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_simon_autoplayer.sv
`timescale 1ns/1ps
// Bench for simon_autoplayer: directed games against a timeline model of the expected button/start/busy/game_over trace.
module tb_simon_autoplayer;

    localparam int STEP  = 8;
    localparam int PRESS = 2;
    localparam int GAP   = 5;
    localparam int WLIM  = 40;
    localparam int NCYC  = 1500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] color = 2'd0;
    logic       color_en = 1'b0;
    logic [7:0] round = 8'd0;
    logic       start_btn, red_btn, green_btn, blue_btn, yellow_btn;
    logic       busy, seq_err, game_over;
    logic [7:0] rec_len;
    logic [3:0] btn;

    assign btn = {yellow_btn, blue_btn, green_btn, red_btn};

    simon_autoplayer #(
        .STEP_CYCLES (STEP),
        .PRESS_CYCLES(PRESS),
        .GAP_CYCLES  (GAP),
        .WAIT_LIMIT  (WLIM),
        .MAX_LEN     (251)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .color     (color),
        .color_en  (color_en),
        .round     (round),
        .start_btn (start_btn),
        .red_btn   (red_btn),
        .green_btn (green_btn),
        .blue_btn  (blue_btn),
        .yellow_btn(yellow_btn),
        .busy      (busy),
        .seq_err   (seq_err),
        .game_over (game_over),
        .rec_len   (rec_len)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; expectation arrays are indexed by it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle trace (all-zero unless the model schedules something).
    bit [3:0] e_btn   [NCYC];
    bit       e_start [NCYC];
    bit       e_busy  [NCYC];
    bit       e_go    [NCYC];

    // Game-level model: last recorded sequence, its length and the sticky error.
    int       mdl_rec_len = 0;
    bit       mdl_err = 1'b0;
    int       prev_seq [8];
    logic [1:0] seq_buf [8];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        nvec++;
        if (act !== 32'(exp)) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic fill_busy(input int from, input bit v);
        for (int i = from; i < NCYC; i++) e_busy[i] = v;
    endtask

    // The player leaves the game at cycle c: idle from then on, any pending presses cancelled.
    task automatic abort_at(input int c);
        fill_busy(c, 1'b0);
        for (int i = c; i < NCYC; i++) e_btn[i] = 4'b0000;
    endtask

    task automatic start_game();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        e_start[cyc + 1] = 1'b1;
        fill_busy(cyc + 1, 1'b1);
        mdl_err = 1'b0;
        mdl_rec_len = 0;
        tick();
        chk("start_pulse", start_btn, 1);
        chk("start_busy", busy, 1);
        tick();
        chk("start_once", start_btn, 0);
        chk("start_rec_len", rec_len, mdl_rec_len);
        chk("start_err", seq_err, int'(mdl_err));
    endtask

    // The game shows n colours from seq_buf, STEP cycles each, then drops color_en.
    // Playback rule: presses start one cycle after the first edge that sees color_en low,
    // each press PRESS cycles followed by GAP quiet cycles; the player is back waiting after the last gap.
    task automatic show_round(input int n, input int rnd, output int base, output int w);
        int s0;
        s0 = cyc;
        round = 8'(rnd);
        color_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            color = seq_buf[k];
            repeat (STEP) tick();
        end
        color_en = 1'b0;
        base = s0 + STEP * n + 2;
        for (int k = 0; k < n; k++)
            for (int p = 0; p < PRESS; p++)
                e_btn[base + k * (PRESS + GAP) + p] = 4'b0001 << seq_buf[k];
        for (int k = 0; k < n; k++) begin
            if (k < mdl_rec_len && int'(seq_buf[k]) != prev_seq[k]) mdl_err = 1'b1;
            prev_seq[k] = int'(seq_buf[k]);
        end
        mdl_rec_len = n;
        w = base + n * (PRESS + GAP);
    endtask

    task automatic bad_round(input int rnd);
        start_game();
        round = 8'(rnd);
        color = 2'd0;
        color_en = 1'b1;
        abort_at(cyc + 1);
        mdl_err = 1'b1;
        tick();
        tick();
        chk("badround_err", seq_err, 1);
        chk("badround_busy", busy, 0);
        color_en = 1'b0;
        tick();
    endtask

    // Whole-trace compare, away from the rising edge.
    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk("trace_btn", btn, int'(e_btn[cyc]));
            chk("trace_start", start_btn, int'(e_start[cyc]));
            chk("trace_busy", busy, int'(e_busy[cyc]));
            chk("trace_game_over", game_over, int'(e_go[cyc]));
        end
    end

    initial begin
        int base, w, s0;

        // Reset with enable already high: no game may start after release.
        rst = 1'b1;
        enable = 1'b1;
        #2;
        chk("rst_btn", btn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_btn, 0);
        chk("rst_rec_len", rec_len, 0);
        chk("rst_err", seq_err, 0);
        chk("rst_go", game_over, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();

        // Game A: blue, then blue-yellow, then the game goes quiet.
        start_game();
        seq_buf[0] = 2'd2;
        show_round(1, 1, base, w);
        wait_until(base);
        chk("lit_blue_first", btn, 4);
        tick();
        chk("lit_blue_second", btn, 4);
        tick();
        chk("lit_gap_low", btn, 0);
        wait_until(w);
        chk("r1_rec_len", rec_len, 1);
        chk("r1_err", seq_err, 0);
        chk("r1_busy", busy, 1);
        seq_buf[0] = 2'd2;
        seq_buf[1] = 2'd3;
        show_round(2, 2, base, w);
        wait_until(base + PRESS + GAP);
        chk("lit_yellow", btn, 8);
        wait_until(w);
        chk("r2_rec_len", rec_len, mdl_rec_len);
        chk("r2_err", seq_err, int'(mdl_err));
        e_go[w + WLIM] = 1'b1;
        abort_at(w + WLIM);
        wait_until(w + WLIM);
        chk("timeout_pulse", game_over, 1);
        chk("timeout_idle", busy, 0);
        tick();
        chk("timeout_once", game_over, 0);

        // Game B: blue, then green-red (wrong prefix), then abort during playback.
        start_game();
        seq_buf[0] = 2'd2;
        show_round(1, 1, base, w);
        wait_until(w);
        seq_buf[0] = 2'd1;
        seq_buf[1] = 2'd0;
        show_round(2, 2, base, w);
        wait_until(base);
        chk("lit_green", btn, 2);
        wait_until(base + PRESS + GAP);
        chk("lit_red", btn, 1);
        wait_until(w);
        chk("mismatch_err", seq_err, 1);
        chk("mismatch_model_err", seq_err, int'(mdl_err));
        chk("mismatch_rec_len", rec_len, mdl_rec_len);
        seq_buf[0] = 2'd1;
        seq_buf[1] = 2'd0;
        seq_buf[2] = 2'd2;
        show_round(3, 3, base, w);
        wait_until(base);
        enable = 1'b0;
        abort_at(cyc + 1);
        tick();
        chk("abort_btn", btn, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err_hold", seq_err, int'(mdl_err));
        chk("abort_len_hold", rec_len, mdl_rec_len);

        // Game C: out-of-range rounds.
        bad_round(0);
        bad_round(252);

        // Game D: colour strobe drops after one of two items.
        start_game();
        round = 8'd2;
        color = 2'd1;
        color_en = 1'b1;
        s0 = cyc;
        repeat (STEP) tick();
        color_en = 1'b0;
        abort_at(s0 + STEP + 1);
        mdl_err = 1'b1;
        wait_until(s0 + STEP + 2);
        chk("early_end_err", seq_err, 1);
        chk("early_end_busy", busy, 0);
        chk("early_end_len", rec_len, 0);

        // Game E: reset lands in the middle of recording.
        start_game();
        seq_buf[0] = 2'd1;
        show_round(1, 1, base, w);
        wait_until(w);
        chk("e_rec_len", rec_len, 1);
        round = 8'd2;
        color = 2'd3;
        color_en = 1'b1;
        repeat (5) tick();
        fill_busy(cyc, 1'b0);
        mdl_rec_len = 0;
        mdl_err = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_btn", btn, 0);
        chk("midrst_start", start_btn, 0);
        chk("midrst_rec_len", rec_len, mdl_rec_len);
        chk("midrst_err", seq_err, 0);
        chk("midrst_go", game_over, 0);
        tick();
        color_en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("post_rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
